// File: rtl/axil_sram_ctrl.sv
// AXI4-Lite slave in front of an internal single-port SRAM with byte enables.
// AW and W are each captured in a one-entry holding register. A write issues
// once both entries are full and the B slot is free. A read issues directly
// from the AR channel in the cycle it is accepted. When a read and a write
// both want the same cycle, a round-robin flag picks between them.
`timescale 1ns/1ps

module axil_sram_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // write address channel
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    // write data channel
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    // write response channel
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    // read address channel
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    // read data channel
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int BYTE_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // holding registers
    logic                 aw_held_reg;
    logic                 w_held_reg;
    logic [ADDR_W-1:0]    awaddr_reg;
    logic [DATA_W-1:0]    wdata_reg;
    logic [STRB_W-1:0]    wstrb_reg;

    // response registers
    logic                 bvalid_reg;
    logic [1:0]           bresp_reg;
    logic                 rvalid_reg;
    logic [1:0]           rresp_reg;
    logic [DATA_W-1:0]    rdata_reg;

    // 1 = the most recent grant was a read
    logic                 last_rd_reg;

    logic                 wr_elig;
    logic                 rd_elig;
    logic                 wr_grant;
    logic                 rd_grant;
    logic                 wr_oor;
    logic                 rd_oor;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;

    logic [DATA_W-1:0]    mem [DEPTH];

    // Eligibility, round-robin arbitration and address decode.
    // A word index at or beyond DEPTH is out of range. The whole shifted
    // address is compared, so any set upper bit counts as out of range.
    always_comb begin
        wr_elig  = aw_held_reg && w_held_reg && (!bvalid_reg || bready);
        rd_elig  = arvalid && (!rvalid_reg || rready);
        wr_grant = wr_elig && (!rd_elig || last_rd_reg);
        rd_grant = rd_elig && (!wr_elig || !last_rd_reg);
        wr_oor   = (awaddr_reg >> BYTE_LSB) >= DEPTH_A;
        rd_oor   = (araddr >> BYTE_LSB) >= DEPTH_A;
        wr_idx   = awaddr_reg[BYTE_LSB +: IDX_W];
        rd_idx   = araddr[BYTE_LSB +: IDX_W];
    end

    assign awready = !aw_held_reg;
    assign wready  = !w_held_reg;
    assign arready = rd_grant;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;
    assign rvalid  = rvalid_reg;
    assign rresp   = rresp_reg;
    assign rdata   = rdata_reg;

    // AW holding register: fill on handshake, drain on write grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_reg <= 1'b0;
            awaddr_reg  <= '0;
        end else if (wr_grant) begin
            aw_held_reg <= 1'b0;
        end else if (awvalid && !aw_held_reg) begin
            aw_held_reg <= 1'b1;
            awaddr_reg  <= awaddr;
        end
    end

    // W holding register: fill on handshake, drain on write grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_held_reg <= 1'b0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
        end else if (wr_grant) begin
            w_held_reg <= 1'b0;
        end else if (wvalid && !w_held_reg) begin
            w_held_reg <= 1'b1;
            wdata_reg  <= wdata;
            wstrb_reg  <= wstrb;
        end
    end

    // Byte-enabled memory write. Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_grant && !wr_oor) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_reg[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wdata_reg[b*8 +: 8];
                end
            end
        end
    end

    // Read data register: load on grant, otherwise hold until handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            rdata_reg  <= '0;
        end else if (rd_grant) begin
            rvalid_reg <= 1'b1;
            rresp_reg  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
            rdata_reg  <= rd_oor ? '0 : mem[rd_idx];
        end else if (rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    // Write response register: load on grant, otherwise hold until handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
        end else if (wr_grant) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (bready) begin
            bvalid_reg <= 1'b0;
        end
    end

    // Round-robin flag. It starts as "read", so the first conflict goes to the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd_reg <= 1'b1;
        end else if (wr_grant) begin
            last_rd_reg <= 1'b0;
        end else if (rd_grant) begin
            last_rd_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axil_sram_ctrl.sv
// Directed testbench for axil_sram_ctrl (DEPTH=1024, DATA_W=32).
`timescale 1ns/1ps

module tb_axil_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    axil_sram_ctrl #(
        .DATA_W(32),
        .ADDR_W(32),
        .DEPTH (1024)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er, input string tag);
        logic aw_ok;
        logic w_ok;
        logic b_ok;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_ok = 1'b0; w_ok = 1'b0; b_ok = 1'b0;
        for (int n = 0; n < 20 && !(aw_ok && w_ok); n++) begin
            @(negedge clk);
            if (awvalid && awready) aw_ok = 1'b1;
            if (wvalid && wready) w_ok = 1'b1;
            tick();
            if (aw_ok) awvalid = 1'b0;
            if (w_ok) wvalid = 1'b0;
        end
        for (int n = 0; n < 20 && !b_ok; n++) begin
            @(negedge clk);
            if (bvalid) begin
                b_ok = 1'b1;
                check_eq({tag, "_bresp"}, bresp, er);
            end
            tick();
        end
        check_eq({tag, "_bdone"}, b_ok, 1);
        $display("wr %s addr=0x%08h data=0x%08h strb=0x%0h bresp=%02b", tag, a, d, s, bresp);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                           input string tag);
        logic ar_ok;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        ar_ok = 1'b0;
        for (int n = 0; n < 20 && !ar_ok; n++) begin
            @(negedge clk);
            if (arready) ar_ok = 1'b1;
            tick();
        end
        arvalid = 1'b0;
        check_eq({tag, "_ardone"}, ar_ok, 1);
        @(negedge clk);
        check_eq({tag, "_rvalid"}, rvalid, 1);
        check_eq({tag, "_rdata"}, rdata, ed);
        check_eq({tag, "_rresp"}, rresp, er);
        $display("rd %s addr=0x%08h rdata=0x%08h rresp=%02b", tag, a, rdata, rresp);
        tick();
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_bvalid", bvalid, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_bresp", bresp, 0);
        check_eq("rst_rresp", rresp, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_awready", awready, 1);
        check_eq("rel_wready", wready, 1);
        check_eq("rel_arready_idle", arready, 0);
        arvalid = 1'b1;
        #1;
        check_eq("rel_arready_req", arready, 1);
        arvalid = 1'b0;
        tick();

        // ---------------- continuous AR + AW/W ----------------
        awaddr = 32'h40; wdata = 32'h1; wstrb = 4'hF; araddr = 32'h40;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check_eq($sformatf("stream%0d_arready", k), arready, (k % 2 == 0));
            check_eq($sformatf("stream%0d_awready", k), awready, (k % 2 == 0));
            check_eq($sformatf("stream%0d_bvalid", k), bvalid, (k % 2 == 0));
            check_eq($sformatf("stream%0d_rvalid", k), rvalid, (k >= 3 && k % 2 == 1));
            $display("stream cycle %0d arready=%0b awready=%0b bvalid=%0b rvalid=%0b",
                     k, arready, awready, bvalid, rvalid);
            tick();
        end
        // reset pulse mid-stream
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        check_eq("midrst_bvalid", bvalid, 0);
        check_eq("midrst_rvalid", rvalid, 0);
        check_eq("midrst_awready", awready, 1);
        check_eq("midrst_wready", wready, 1);
        check_eq("midrst_rdata", rdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrel_awready", awready, 1);
        check_eq("midrel_wready", wready, 1);
        check_eq("midrel_arready", arready, 1);
        check_eq("midrel_bvalid", bvalid, 0);
        tick();
        arvalid = 1'b0;
        tick();
        tick();

        // ---------------- basic write / read ----------------
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, "w_full");
        do_read (32'h10, 32'hDEADBEEF, 2'b00, "r_full");
        do_write(32'h10, 32'h11223344, 4'h3, 2'b00, "w_strb3");
        do_read (32'h10, 32'hDEAD3344, 2'b00, "r_strb3");

        // ---------------- out of range ----------------
        do_write(32'h0, 32'hCAFEF00D, 4'hF, 2'b00, "w_word0");
        do_write(32'h1000, 32'h12345678, 4'hF, 2'b10, "w_oor");
        do_read (32'h0, 32'hCAFEF00D, 2'b00, "r_word0");
        do_read (32'h1000, 32'h0, 2'b10, "r_oor");

        // ---------------- wstrb = 0 ----------------
        do_write(32'h10, 32'hFFFFFFFF, 4'h0, 2'b00, "w_strb0");
        do_read (32'h10, 32'hDEAD3344, 2'b00, "r_strb0");

        // ---------------- W ahead of AW ----------------
        wdata = 32'hA5A55A5A; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        check_eq("wfirst_wready", wready, 1);
        tick();
        wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("wfirst_wait%0d_wready", k), wready, 0);
            check_eq($sformatf("wfirst_wait%0d_bvalid", k), bvalid, 0);
            tick();
        end
        awaddr = 32'h30; awvalid = 1'b1;
        @(negedge clk);
        check_eq("wfirst_awready", awready, 1);
        tick();
        awvalid = 1'b0;
        @(negedge clk);
        check_eq("wfirst_bvalid_n", bvalid, 0);
        tick();
        @(negedge clk);
        check_eq("wfirst_bvalid_n1", bvalid, 1);
        check_eq("wfirst_bresp", bresp, 0);
        tick();
        do_read(32'h30, 32'hA5A55A5A, 2'b00, "r_wfirst");

        // ---------------- B back-pressure ----------------
        bready = 1'b0;
        awaddr = 32'h2000; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awaddr = 32'h24; wdata = 32'h2;
        tick();
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("bstall%0d_bvalid", k), bvalid, 1);
            check_eq($sformatf("bstall%0d_bresp", k), bresp, 2'b10);
            check_eq($sformatf("bstall%0d_awready", k), awready, 0);
            check_eq($sformatf("bstall%0d_wready", k), wready, 0);
            tick();
        end
        bready = 1'b1;
        @(negedge clk);
        check_eq("bstall_rel_bresp", bresp, 2'b10);
        tick();
        @(negedge clk);
        check_eq("bstall_second_bvalid", bvalid, 1);
        check_eq("bstall_second_bresp", bresp, 2'b00);
        tick();
        @(negedge clk);
        check_eq("bstall_drained", bvalid, 0);
        tick();
        do_read(32'h24, 32'h2, 2'b00, "r_bstall2");
        do_read(32'h0, 32'hCAFEF00D, 2'b00, "r_bstall_word0");

        // ---------------- R back-pressure ----------------
        rready = 1'b0;
        araddr = 32'h10; arvalid = 1'b1;
        @(negedge clk);
        check_eq("rstall_arready0", arready, 1);
        tick();
        araddr = 32'h24;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("rstall%0d_rvalid", k), rvalid, 1);
            check_eq($sformatf("rstall%0d_rdata", k), rdata, 32'hDEAD3344);
            check_eq($sformatf("rstall%0d_arready", k), arready, 0);
            tick();
        end
        rready = 1'b1;
        @(negedge clk);
        check_eq("rstall_rel_arready", arready, 1);
        tick();
        arvalid = 1'b0;
        @(negedge clk);
        check_eq("rstall_next_rvalid", rvalid, 1);
        check_eq("rstall_next_rdata", rdata, 32'h2);
        tick();
        @(negedge clk);
        check_eq("rstall_drained", rvalid, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
